tempo_tracker: RTL

Parametrised successor to the camera-domain BPM block. It measures conducting tempo by counting baton hits over a configurable window, or passes through a manually entered tempo. Its clamped, registered BPM feeds the note scheduler. It also drives an LED countdown bar. Compared with the earlier block, it counts rising edges rather than high cycles, clamps the result, aborts cleanly on a mode change, and pulses `bpm_valid_out` when a new value is available.

---
 rtl/tempo_pkg.sv | 21 ++
 rtl/rise_detect.sv | 18 +
 rtl/tempo_tracker.sv | 136 +++++++++++++
 3 files changed

// File: rtl/tempo_pkg.sv
// tempo_pkg: shared mode/state encodings and the bounded clamp used by tempo_tracker.
package tempo_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'd0,
        MODE_BATON    = 2'd1,
        MODE_OVERRIDE = 2'd2
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MEASURE,
        S_DONE,
        S_OVERRIDE
    } state_t;

    function automatic logic [31:0] clamp(input logic [31:0] v, input logic [31:0] lo, input logic [31:0] hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered 1-bit rising-edge detector, reusable for any synchronous sensor level.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) d_q <= 1'b0;
        else         d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/tempo_tracker.sv
// tempo_tracker: baton-hit tempo measurement over a fixed window, or clamped manual override,
// with a registered BPM output, new-value pulse and LED countdown bar.
module tempo_tracker
    import tempo_pkg::*;
#(
    parameter int CLK_HZ      = 200_000_000,
    parameter int WINDOW_S    = 15,
    parameter int LED_W       = 15,
    parameter int BPM_W       = 8,
    parameter int DEFAULT_BPM = 120,
    parameter int MIN_BPM     = 30,
    parameter int MAX_BPM     = 240
) (
    input  logic             clk_camera_in,
    input  logic             rst_n_in,
    input  logic             hit_in,
    input  logic [1:0]       mode_in,
    input  logic [BPM_W-1:0] bpm_in,
    output logic [BPM_W-1:0] bpm_out,
    output logic             bpm_valid_out,
    output logic             busy_out,
    output logic [LED_W-1:0] led_out
);

    localparam logic [63:0] WC    = 64'(CLK_HZ) * 64'(WINDOW_S);
    localparam logic [63:0] TICK  = WC / 64'(LED_W);
    localparam int          SCALE = 60 / WINDOW_S;
    localparam int          HW    = $clog2(MAX_BPM * WINDOW_S / 60 + 1) + 1;
    localparam int          CW    = (WC > 1) ? $clog2(WC) : 1;
    localparam int          TW    = (TICK > 1) ? $clog2(TICK) : 1;
    localparam int          PW    = HW + $clog2(SCALE + 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [HW-1:0]    hits_q, hits_d;
    logic [LED_W-1:0] led_q, led_d;
    logic [BPM_W-1:0] bpm_q, bpm_d;
    logic             valid_q, valid_d;
    logic [1:0]       mode_prev_q, mode_prev_d;
    logic             rise, baton, ovr, tick_end;
    logic [PW-1:0]    prod;
    logic [BPM_W-1:0] ovr_bpm, meas_bpm;

    rise_detect u_rise (
        .clk_i  (clk_camera_in),
        .rst_ni (rst_n_in),
        .d_i    (hit_in),
        .rise_o (rise)
    );

    assign baton    = mode_in == MODE_BATON;
    assign ovr      = mode_in == MODE_OVERRIDE;
    assign tick_end = tick_q == TW'(TICK - 1);
    assign prod     = PW'(hits_q) * PW'(SCALE);
    assign ovr_bpm  = BPM_W'(clamp(32'(bpm_in), 32'(MIN_BPM), 32'(MAX_BPM)));
    assign meas_bpm = BPM_W'(clamp(32'(prod), 32'(MIN_BPM), 32'(MAX_BPM)));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tick_d      = tick_q;
        hits_d      = hits_q;
        led_d       = led_q;
        bpm_d       = bpm_q;
        valid_d     = 1'b0;
        // leaving OVERRIDE forgets the mode history so a direct 2->1 switch still arms
        mode_prev_d = (state_q == S_OVERRIDE) ? 2'(MODE_IDLE) : mode_in;
        case (state_q)
            S_IDLE: begin
                if (baton && mode_prev_q != 2'(MODE_BATON)) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                    tick_d  = '0;
                    hits_d  = '0;
                    led_d   = '1;
                end else if (ovr) begin
                    state_d = S_OVERRIDE;
                end
            end
            S_MEASURE: begin
                if (!baton) begin
                    state_d = ovr ? S_OVERRIDE : S_IDLE;
                    led_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    tick_d  = tick_end ? '0 : tick_q + TW'(1);
                    hits_d  = hits_q + HW'(rise && !(&hits_q));
                    led_d   = tick_end ? led_q >> 1 : led_q;
                    state_d = (cnt_q == CW'(WC - 1)) ? S_DONE : S_MEASURE;
                end
            end
            S_DONE: begin
                bpm_d   = meas_bpm;
                valid_d = 1'b1;
                led_d   = '1;
                state_d = S_IDLE;
            end
            S_OVERRIDE: begin
                bpm_d   = ovr_bpm;
                valid_d = ovr_bpm != bpm_q;
                led_d   = '0;
                state_d = ovr ? S_OVERRIDE : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_camera_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            tick_q      <= '0;
            hits_q      <= '0;
            led_q       <= '1;
            bpm_q       <= BPM_W'(DEFAULT_BPM);
            valid_q     <= 1'b0;
            mode_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tick_q      <= tick_d;
            hits_q      <= hits_d;
            led_q       <= led_d;
            bpm_q       <= bpm_d;
            valid_q     <= valid_d;
            mode_prev_q <= mode_prev_d;
        end
    end

    assign bpm_out       = bpm_q;
    assign bpm_valid_out = valid_q;
    assign busy_out      = state_q == S_MEASURE;
    assign led_out       = led_q;

endmodule
